// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the score BCD encoder:
//   - state_e       : converter FSM encoding (IDLE, SHIFT, DONE)
//   - BCD_DIGIT_W   : width of one packed BCD digit
//   - SCORE_W       : width of the game score register
//   - SCORE_BCD_MAX : largest score the four-digit display can show
// No ports (package only).
// -----------------------------------------------------------------------------
package snake_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int BCD_DIGIT_W   = 4;
    localparam int SCORE_W       = 20;
    localparam int SCORE_BCD_MAX = 9999;

endpackage : snake_pkg

// File: rtl/score_bcd_encoder_bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble correction cell: a BCD digit of 5 or more gets
// 3 added so that the following left shift carries correctly into the next
// decimal digit.
// Ports:
//   digit_i : input  BCD digit before correction
//   digit_o : output BCD digit after correction
// -----------------------------------------------------------------------------
module bcd_add3
    import snake_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    always_comb begin
        if (digit_i >= BCD_DIGIT_W'(5)) begin
            digit_o = digit_i + BCD_DIGIT_W'(3);
        end else begin
            digit_o = digit_i;
        end
    end

endmodule : bcd_add3

// File: rtl/score_bcd_encoder.sv
// -----------------------------------------------------------------------------
// score_bcd_encoder
// Iterative binary-to-BCD converter (shift-add-3) feeding the seven-segment
// scoreboard. The game core requests a conversion with start; the result is
// published on bcd in a single update when the conversion finishes, so the
// display never shows partially converted digits.
//
// Ports:
//   clock_100Mhz : input  system clock
//   reset        : input  synchronous, active-high reset
//   start        : input  conversion request, accepted when busy=0
//   bin_in       : input  [BIN_W-1:0] binary score, sampled on acceptance
//   bcd          : output [4*DIGITS-1:0] registered BCD result, units in [3:0]
//   busy         : output high while a conversion is running
//   done         : output one-cycle pulse when bcd has just been updated
//   overflow     : output input exceeded BCD_MAX (result saturated); held
//                  until the next done
//   blank        : output [DIGITS-1:0] leading-zero blank mask, 1 = blank
//
// Build option:
//   LEADING_ZERO_BLANK_EN : when defined, blank is registered with bcd and
//                           marks leading zero digits (digit 0 never blank).
//                           When undefined, blank is constant 0.
// -----------------------------------------------------------------------------
module score_bcd_encoder
    import snake_pkg::*;
#(
    parameter int BIN_W   = SCORE_W,
    parameter int DIGITS  = 4,
    parameter int BCD_MAX = SCORE_BCD_MAX
) (
    input  logic                          clock_100Mhz,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic [DIGITS-1:0]             blank
);

    localparam int              SCR_W   = BCD_DIGIT_W * DIGITS;
    localparam int              CNT_W   = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(BCD_MAX);

    // Saturate the score to what the display can represent; this also keeps
    // the shift-add-3 scratch from carrying out of the top digit.
    function automatic logic [BIN_W-1:0] sat_clamp(input logic [BIN_W-1:0] v);
        return (v > MAX_BIN) ? MAX_BIN : v;
    endfunction

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [SCR_W-1:0]   scratch_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               capture;

    // Per-digit add-3 correction applied before every shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The counter is loaded with BIN_W and reaches zero after the last shift;
    // the cycle spent in SHIFT with a zero count publishes the scratch result.
    assign capture = (state_q == SHIFT) && (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    shift_d    = sat_clamp(bin_in);
                    ovf_pend_d = (bin_in > MAX_BIN);
                    scratch_d  = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    state_d    = SHIFT;
                end else begin
                    state_d    = IDLE;
                end
            end
            SHIFT: begin
                if (capture) begin
                    bcd_d   = scratch_q;
                    ovf_d   = ovf_pend_q;
                    state_d = DONE;
                end else begin
                    {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
                    cnt_d                = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every digit above it are zero; the units
    // digit always stays lit so a zero score still shows "0".
    function automatic logic [DIGITS-1:0] blank_mask(input logic [SCR_W-1:0] d);
        logic [DIGITS-1:0] m;
        logic              all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero && (d[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            m[i]     = all_zero;
        end
        return m;
    endfunction

    logic [DIGITS-1:0] blank_q;

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            blank_q <= '0;
        end else if (capture) begin
            blank_q <= blank_mask(scratch_q);
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    assign bcd      = bcd_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);

endmodule : score_bcd_encoder

// File: tb/tb_score_bcd_encoder.sv
// -----------------------------------------------------------------------------
// tb_score_bcd_encoder
// Scoreboard bench: the driver pushes the expected result of every accepted
// request into a queue; a monitor pops and compares each time done pulses,
// and checks that bcd/overflow hold their previous values while busy.
// -----------------------------------------------------------------------------
module tb_score_bcd_encoder;

    localparam int LAT = 21;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
        int          acc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [19:0] bin_in;
    logic [15:0] bcd;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [3:0]  blank;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t q[$];
    logic [15:0] held_bcd = 16'h0000;
    logic        held_ovf = 1'b0;

    score_bcd_encoder dut (
        .clock_100Mhz (clk),
        .reset        (reset),
        .start        (start),
        .bin_in       (bin_in),
        .bcd          (bcd),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .blank        (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] exp_blank(input logic [3:0] m);
`ifdef LEADING_ZERO_BLANK_EN
        return m;
`else
        return (m & 4'b0000);
`endif
    endfunction

    // Drive a one-cycle start, record the accepting edge, push the expectation.
    task automatic issue(input logic [19:0] v, input logic [15:0] eb,
                         input logic eo, input logic [3:0] em);
        exp_t e;
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        #1;
        start   = 1'b0;
        e.bcd   = eb;
        e.ovf   = eo;
        e.blank = exp_blank(em);
        e.acc   = cyc;
        q.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: compare on every done, check hold behaviour while busy.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, expected no pulse (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("bcd", 32'(bcd), 32'(e.bcd));
                    check("overflow", 32'(overflow), 32'(e.ovf));
                    check("blank", 32'(blank), 32'(e.blank));
                    check("latency", 32'(cyc - e.acc), 32'(LAT));
                    held_bcd = e.bcd;
                    held_ovf = e.ovf;
                end
            end else if (busy) begin
                check("bcd_hold", 32'(bcd), 32'(held_bcd));
                check("ovf_hold", 32'(overflow), 32'(held_ovf));
            end
        end
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_blank", 32'(blank), 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Zero and a plain value.
        issue(20'd0, 16'h0000, 1'b0, 4'b1110);
        drain();
        issue(20'd1234, 16'h1234, 1'b0, 4'b0000);
        drain();

        // Back-to-back: second start lands in the DONE cycle of the first.
        issue(20'd9999, 16'h9999, 1'b0, 4'b0000);
        repeat (LAT) @(posedge clk);
        #1;
        check("b2b_done_cycle", 32'(done), 32'h1);
        issue(20'd10000, 16'h9999, 1'b1, 4'b0000);
        drain();

        // Maximum input saturates; small values exercise the blank mask.
        issue(20'hFFFFF, 16'h9999, 1'b1, 4'b0000);
        drain();
        issue(20'd7, 16'h0007, 1'b0, 4'b1110);
        drain();
        issue(20'd42, 16'h0042, 1'b0, 4'b1100);
        drain();

        // start held for 30 cycles with bin_in = 100+i: only i=0 and i=22
        // (the DONE cycle of the first conversion) are accepted.
        for (int i = 0; i < 30; i++) begin
            exp_t e;
            start  = 1'b1;
            bin_in = 20'(100 + i);
            @(posedge clk);
            #1;
            if (i == 0 || i == 22) begin
                e.bcd   = (i == 0) ? 16'h0100 : 16'h0122;
                e.ovf   = 1'b0;
                e.blank = exp_blank(4'b1000);
                e.acc   = cyc;
                q.push_back(e);
            end
        end
        start = 1'b0;
        drain();

        // Reset at shift iteration 10 aborts the conversion without done.
        issue(20'd4567, 16'h4567, 1'b0, 4'b0000);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        reset    = 1'b0;
        held_bcd = 16'h0000;
        held_ovf = 1'b0;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_bcd", 32'(bcd), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_overflow", 32'(overflow), 32'h0);
        repeat (30) @(posedge clk);
        #1;
        issue(20'd4567, 16'h4567, 1'b0, 4'b0000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_score_bcd_encoder

// File: doc/score_bcd_encoder.md
Name: score_bcd_encoder

Overview:
Sequential binary-to-BCD converter that produces the four decimal score digits consumed by the seven-segment scoreboard scan.
- Replaces the combinational divide/modulo digit extraction with an iterative shift-add-3 (double-dabble) engine.
- Writer side of the digit interface: the game core requests a conversion with a start/done handshake.
- The scoreboard mux reads the registered digits at any time.

Parameters:
BIN_W, 20, width of binary input (score register width)
DIGITS, 4, number of BCD output digits
BCD_MAX, 9999, saturation limit; must equal 10^DIGITS - 1

Ports:
clock_100Mhz  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  conversion request; accepted only when busy=0
bin_in  input  BIN_W  binary value; sampled on the accepting edge only
bcd  output  4*DIGITS  result; digit 0 (units) in [3:0], thousands in [15:12]; registered
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd has just been updated
overflow  output  1  set with done when bin_in exceeded BCD_MAX; held until the next done
blank  output  DIGITS  leading-zero blank mask, 1 = digit blank (see Optional Feature)

Behaviour:
- One clock, clock_100Mhz. Reset is synchronous and active-high.
- Reset values: bcd=0, busy=0, done=0, overflow=0, blank=0; state=IDLE; internal shift and scratch registers cleared.
- FSM states:
  - IDLE: busy=0. start=1 latches bin_in, clamps it to BCD_MAX when bin_in>BCD_MAX (records overflow internally), clears scratch to 0, loads iteration counter with BIN_W, then goes to SHIFT.
  - SHIFT: busy=1. Each cycle:
    - add 3 to every scratch digit >=5;
    - shift {scratch, shiftreg} left by 1;
    - decrement the counter.
    - After the BIN_W-th shift, go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle. bcd and overflow register the scratch result on entry. start=1 here is accepted exactly as in IDLE (back-to-back), otherwise return to IDLE.
- Latency: start accepted at edge N -> busy high from N to N+BIN_W; done high in the cycle after edge N+BIN_W+1. Start-to-done is BIN_W+1 cycles (21 at default).
- bcd holds the previous result for the whole conversion, so the scoreboard never displays partial digits.
- start while busy=1 is ignored. bin_in changes after acceptance have no effect.
- Arithmetic: scratch is 4*DIGITS bits. The clamp guarantees no carry out of the top digit. Every digit value is 0..9 at all times on bcd.
- Boundary values:
  - bin_in=0 -> bcd=0x0000.
  - bin_in=BCD_MAX -> 0x9999 with overflow=0.
  - bin_in=BCD_MAX+1 up to 2^BIN_W-1 -> 0x9999 with overflow=1.
- Reset asserted mid-conversion: abort, return to IDLE with all outputs at reset values. No done pulse.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: blank is registered alongside bcd on DONE. A digit is marked blank when it and every higher digit are 0. Digit 0 is never blanked.
- Undefined: blank is tied to 0 and the mask logic is absent.

Decomposition:
- Shared package (snake_pkg):
  - FSM state encoding: IDLE, SHIFT, DONE.
  - BCD_DIGIT_W=4.
  - SCORE_W=20.
  - SCORE_BCD_MAX=9999.
- One natural sub-module: bcd_add3, a combinational 4-bit "add 3 if >=5" cell, instantiated DIGITS times via generate inside the SHIFT datapath.

Test Plan:
- bin_in=0, start pulse -> done exactly 21 cycles after the accepting edge, bcd=0x0000, overflow=0.
- bin_in=1234 -> bcd=0x1234. bcd keeps its old value (0x0000) on every cycle while busy=1.
- bin_in=9999, then a back-to-back start issued in the DONE cycle with bin_in=10000:
  - first result: bcd=0x9999, overflow=0;
  - second result: bcd=0x9999, overflow=1, arriving 21 cycles later.
- start held high for 30 cycles with bin_in changing each cycle -> only the first value and the DONE-cycle value are converted. Mid-conversion starts are ignored.
- reset asserted at SHIFT iteration 10 of bin_in=4567 -> next cycle busy=0, bcd=0, no done pulse. A fresh start of 4567 then yields 0x4567.
- LEADING_ZERO_BLANK_EN defined:
  - bin_in=42 -> bcd=0x0042, blank=4'b1100;
  - bin_in=0 -> blank=4'b1110;
  - macro undefined -> blank=4'b0000 for both.
